// File: rtl/jump_resolve_if.sv
// ID-stage jump resolution bundle: decode/hazard inputs from the pipeline,
// redirect/flush/link/statistics outputs back to it.
interface jump_resolve_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 16
);
  logic [31:0]       instr_i;
  logic              instr_valid_i;
  logic [ADDR_W-1:0] pc_plus4_i;
  logic [31:0]       rs_data_i;
  logic              ex_regwrite_i;
  logic [4:0]        ex_rd_i;
  logic              mem_regwrite_i;
  logic              mem_memread_i;
  logic [4:0]        mem_rd_i;
  logic [31:0]       mem_fwd_data_i;
  logic              flush_i;

  logic              stall_o;
  logic              redirect_o;
  logic [ADDR_W-1:0] target_o;
  logic              flush_o;
  logic              link_we_o;
  logic [4:0]        link_rd_o;
  logic [ADDR_W-1:0] link_data_o;
  logic [CNT_W-1:0]  redirect_cnt_o;
  logic              err_o;

  modport master (
    output instr_i, instr_valid_i, pc_plus4_i, rs_data_i, ex_regwrite_i, ex_rd_i,
           mem_regwrite_i, mem_memread_i, mem_rd_i, mem_fwd_data_i, flush_i,
    input  stall_o, redirect_o, target_o, flush_o, link_we_o, link_rd_o,
           link_data_o, redirect_cnt_o, err_o
  );

  modport slave (
    input  instr_i, instr_valid_i, pc_plus4_i, rs_data_i, ex_regwrite_i, ex_rd_i,
           mem_regwrite_i, mem_memread_i, mem_rd_i, mem_fwd_data_i, flush_i,
    output stall_o, redirect_o, target_o, flush_o, link_we_o, link_rd_o,
           link_data_o, redirect_cnt_o, err_o
  );
endinterface

// File: rtl/jump_resolve_unit.sv
// ID-stage jump detector/resolver: decodes jr/jalr (and optionally j/jal), waits out
// rs hazards, then issues a one-cycle registered PC redirect with flush and link write.
module jump_resolve_unit #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned ENABLE_J = 1,
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic           clk_i,
  input  logic           rst_i,
  jump_resolve_if.slave  jb
);
  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_REDIRECT} state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q;
  logic [ADDR_W-1:0] target_q, link_data_q;
  logic [4:0]        link_rd_q;
  logic              link_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              err_q;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic        is_jr, is_jalr, is_j, is_jal, rs_jump, is_jump, is_link;
  logic        hazard, fwd_mem;
  logic [31:0] src_val;
  logic [ADDR_W-1:0] target_d;
  logic [4:0]  link_rd_d;

  logic stall, capture, wait_load, wait_inc, err_set, redir, cnt_inc;

  assign op    = jb.instr_i[31:26];
  assign rs    = jb.instr_i[25:21];
  assign rt    = jb.instr_i[20:16];
  assign rd    = jb.instr_i[15:11];
  assign shamt = jb.instr_i[10:6];
  assign funct = jb.instr_i[5:0];

  always_comb begin
    is_jr   = jb.instr_valid_i && op == 6'd0 && funct == 6'd8 && jb.instr_i[20:6] == '0;
    is_jalr = jb.instr_valid_i && op == 6'd0 && funct == 6'd9 && rt == '0 && shamt == '0;
    is_j    = (ENABLE_J != 0) && jb.instr_valid_i && op == 6'd2;
    is_jal  = (ENABLE_J != 0) && jb.instr_valid_i && op == 6'd3;
    rs_jump = is_jr || is_jalr;
    is_jump = rs_jump || is_j || is_jal;
    is_link = is_jalr || is_jal;

    // $0 is hard-wired, so a pending write to it can never be a real dependency
    hazard  = rs_jump && rs != '0 &&
              ((jb.ex_regwrite_i && jb.ex_rd_i == rs) ||
               (jb.mem_regwrite_i && jb.mem_memread_i && jb.mem_rd_i == rs));
    fwd_mem = jb.mem_regwrite_i && !jb.mem_memread_i && jb.mem_rd_i == rs;
    src_val = fwd_mem ? jb.mem_fwd_data_i : jb.rs_data_i;

    target_d  = rs_jump ? src_val[ADDR_W-1:0]
                        : {jb.pc_plus4_i[ADDR_W-1:28], jb.instr_i[25:0], 2'b00};
    link_rd_d = is_jal ? 5'd31 : (is_jalr ? rd : 5'd0);
  end

  always_comb begin
    state_d   = state_q;
    stall     = 1'b0;
    capture   = 1'b0;
    wait_load = 1'b0;
    wait_inc  = 1'b0;
    err_set   = 1'b0;
    redir     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (is_jump) begin
          if (hazard) begin
            stall     = 1'b1;
            wait_load = 1'b1;
            state_d   = S_WAIT;
          end else begin
            capture = 1'b1;
            state_d = S_REDIRECT;
          end
        end
      end
      S_WAIT: begin
        if (!is_jump) begin
          state_d = S_IDLE;
        end else if (hazard) begin
          if (wait_q == WAIT_W'(MAX_WAIT)) begin
            err_set = 1'b1;
            state_d = S_IDLE;
          end else begin
            stall    = 1'b1;
            wait_inc = 1'b1;
          end
        end else begin
          capture = 1'b1;
          state_d = S_REDIRECT;
        end
      end
      S_REDIRECT: begin
        // whatever sits in ID now is wrong-path, so it is never decoded here
        redir   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (jb.flush_i || rst_i) begin
      state_d   = S_IDLE;
      stall     = 1'b0;
      capture   = 1'b0;
      wait_load = 1'b0;
      wait_inc  = 1'b0;
      err_set   = 1'b0;
      redir     = 1'b0;
    end

    cnt_inc = redir && !(&cnt_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      wait_q      <= '0;
      target_q    <= '0;
      link_data_q <= '0;
      link_rd_q   <= '0;
      link_q      <= 1'b0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d != S_WAIT) wait_q <= '0;
      else if (wait_load)    wait_q <= WAIT_W'(1);
      else if (wait_inc)     wait_q <= wait_q + WAIT_W'(1);
      if (capture) begin
        target_q    <= target_d;
        link_data_q <= jb.pc_plus4_i;
        link_rd_q   <= link_rd_d;
        link_q      <= is_link;
      end
      if (cnt_inc) cnt_q <= cnt_q + CNT_W'(1);
      if (err_set) err_q <= 1'b1;
    end
  end

  assign jb.stall_o        = stall;
  assign jb.redirect_o     = redir;
  assign jb.flush_o        = redir;
  assign jb.link_we_o      = redir && link_q;
  assign jb.target_o       = target_q;
  assign jb.link_rd_o      = link_rd_q;
  assign jb.link_data_o    = link_data_q;
  assign jb.redirect_cnt_o = cnt_q;
  assign jb.err_o          = err_q;
endmodule
